// File: rtl/imem_arbiter.sv
// imem_arbiter: shares the single-port synchronous instruction memory between
// the core fetch port and the program loader port. The loader has priority,
// but its streak of grants is bounded while a fetch is waiting, so fetch is
// never starved. Fetched instructions come back one cycle after acceptance.
//
// Optional feature macro: IMEM_READBACK_EN
//   Defined   : every load is followed by a read-back of the written word and
//               a compare; a mismatch sets the sticky err_o.
//   Undefined : no read-back, err_o is tied low, one load per cycle.
module imem_arbiter #(
  parameter int addr_width_p   = 10,
  parameter int starve_limit_p = 4,
  parameter int instr_width_p  = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     fetch_v_i,
  input  logic [addr_width_p-1:0]  fetch_addr_i,
  output logic                     fetch_ready_o,
  output logic                     fetch_v_o,
  output logic [instr_width_p-1:0] fetch_instr_o,
  input  logic                     load_v_i,
  input  logic [addr_width_p-1:0]  load_addr_i,
  input  logic [instr_width_p-1:0] load_instr_i,
  output logic                     load_ready_o,
  input  logic                     load_clear_i,
  output logic [addr_width_p:0]    load_count_o,
  output logic [addr_width_p-1:0]  mem_addr_o,
  output logic [instr_width_p-1:0] mem_instr_o,
  output logic                     mem_wen_o,
  input  logic [instr_width_p-1:0] mem_instr_i,
  output logic                     err_o
);

  localparam int StreakW = $clog2(starve_limit_p + 1);
  localparam logic [StreakW-1:0] StreakMax = StreakW'(starve_limit_p);
  // Saturation value 2**addr_width_p: one word per memory location.
  localparam logic [addr_width_p:0] CountMax = {1'b1, {addr_width_p{1'b0}}};

`ifdef IMEM_READBACK_EN
  typedef enum logic [1:0] {ARB = 2'd0, RB_RD = 2'd1, RB_CMP = 2'd2} state_e;
`else
  typedef enum logic [0:0] {ARB = 1'b0} state_e;
`endif

  state_e                r_state;
  state_e                w_state_nxt;
  logic [StreakW-1:0]    r_streak;
  logic [addr_width_p:0] r_count;
  logic                  r_fetch_v;
  logic                  w_arb;
  logic                  w_load_grant;
  logic                  w_fetch_grant;

  // Arbitration slots: RB_CMP is a normal slot, only RB_RD owns the memory.
`ifdef IMEM_READBACK_EN
  assign w_arb = (r_state == ARB) || (r_state == RB_CMP);
`else
  assign w_arb = (r_state == ARB);
`endif

  // Combinational grants: loader first unless its streak hit the limit while fetch waits.
  always_comb begin
    w_load_grant  = 1'b0;
    w_fetch_grant = 1'b0;
    if (w_arb) begin
      w_load_grant  = load_v_i && (!fetch_v_i || (r_streak < StreakMax));
      w_fetch_grant = fetch_v_i && !w_load_grant;
    end
  end

  assign fetch_ready_o = w_fetch_grant;
  assign load_ready_o  = w_load_grant;
  assign mem_wen_o     = w_load_grant;
  assign mem_instr_o   = load_instr_i;
  assign fetch_v_o     = r_fetch_v;
  assign fetch_instr_o = mem_instr_i;
  assign load_count_o  = r_count;

  // Next-state logic: each accepted load is followed by a read and a compare.
  always_comb begin
    w_state_nxt = r_state;
`ifdef IMEM_READBACK_EN
    case (r_state)
      ARB, RB_CMP: w_state_nxt = w_load_grant ? RB_RD : ARB;
      RB_RD:       w_state_nxt = RB_CMP;
      default:     w_state_nxt = ARB;
    endcase
`else
    w_state_nxt = ARB;
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ARB;
    else          r_state <= w_state_nxt;
  end

  // Loader streak: counts loads granted over a waiting fetch; any fetch grant or idle fetch clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_streak <= '0;
    end else if (w_arb) begin
      if (!fetch_v_i || w_fetch_grant)
        r_streak <= '0;
      else if (w_load_grant && (r_streak != StreakMax))
        r_streak <= r_streak + 1'b1;
    end
  end

  // Saturating count of written words; clear beats a simultaneous grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_count <= '0;
    else if (load_clear_i)
      r_count <= '0;
    else if (w_load_grant && (r_count != CountMax))
      r_count <= r_count + 1'b1;
  end

  // Read data is valid one cycle after a fetch grant; reset drops any outstanding fetch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_fetch_v <= 1'b0;
    else          r_fetch_v <= w_fetch_grant;
  end

`ifdef IMEM_READBACK_EN
  logic [addr_width_p-1:0]  r_rb_addr;
  logic [instr_width_p-1:0] r_rb_data;
  logic                     r_err;

  // Remember what was just written so the read-back can be checked against it.
  always_ff @(posedge clk) begin
    if (w_load_grant) begin
      r_rb_addr <= load_addr_i;
      r_rb_data <= load_instr_i;
    end
  end

  // Sticky error on any read-back mismatch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_err <= 1'b0;
    else if ((r_state == RB_CMP) && (mem_instr_i != r_rb_data))
      r_err <= 1'b1;
  end

  assign err_o = r_err;

  // Memory address: load wins, then the read-back read, else fetch (harmless when idle).
  always_comb begin
    mem_addr_o = fetch_addr_i;
    if (w_load_grant)
      mem_addr_o = load_addr_i;
    else if (r_state == RB_RD)
      mem_addr_o = r_rb_addr;
  end
`else
  assign err_o = 1'b0;

  // Memory address: load wins, else fetch (harmless when idle).
  always_comb begin
    mem_addr_o = fetch_addr_i;
    if (w_load_grant)
      mem_addr_o = load_addr_i;
  end
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Testbench for imem_arbiter: a synchronous memory stub sits behind the
// arbiter, a reference model predicts grants, counts and read data, and
// expected fetch words are queued on grant and checked when fetch_v_o appears.
module tb_imem_arbiter;
  localparam int AW  = 4;
  localparam int LIM = 4;
  localparam int IW  = 32;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          fetch_v_i;
  logic [AW-1:0] fetch_addr_i;
  logic          fetch_ready_o;
  logic          fetch_v_o;
  logic [IW-1:0] fetch_instr_o;
  logic          load_v_i;
  logic [AW-1:0] load_addr_i;
  logic [IW-1:0] load_instr_i;
  logic          load_ready_o;
  logic          load_clear_i;
  logic [AW:0]   load_count_o;
  logic [AW-1:0] mem_addr_o;
  logic [IW-1:0] mem_instr_o;
  logic          mem_wen_o;
  logic [IW-1:0] mem_instr_i;
  logic          err_o;

  always #5 clk = ~clk;

  imem_arbiter #(.addr_width_p(AW), .starve_limit_p(LIM), .instr_width_p(IW)) dut (
    .clk(clk), .reset_n(reset_n),
    .fetch_v_i(fetch_v_i), .fetch_addr_i(fetch_addr_i), .fetch_ready_o(fetch_ready_o),
    .fetch_v_o(fetch_v_o), .fetch_instr_o(fetch_instr_o),
    .load_v_i(load_v_i), .load_addr_i(load_addr_i), .load_instr_i(load_instr_i),
    .load_ready_o(load_ready_o), .load_clear_i(load_clear_i), .load_count_o(load_count_o),
    .mem_addr_o(mem_addr_o), .mem_instr_o(mem_instr_o), .mem_wen_o(mem_wen_o),
    .mem_instr_i(mem_instr_i), .err_o(err_o)
  );

  // Synchronous single-port memory stub; 'corrupt' flips the read data.
  logic [IW-1:0] stub_mem [DEPTH];
  logic [IW-1:0] stub_rd;
  logic          corrupt = 1'b0;
  always @(posedge clk) begin
    if (mem_wen_o) stub_mem[mem_addr_o] <= mem_instr_o;
    stub_rd <= corrupt ? ~stub_mem[mem_addr_o] : stub_mem[mem_addr_o];
  end
  assign mem_instr_i = stub_rd;

  // Reference model state.
  logic [IW-1:0] m_mem [DEPTH];
  int            m_streak = 0;
  int            m_count  = 0;
  int            m_st     = 0;   // 0 arbitrate, 1 read-back read, 2 read-back compare
  logic [AW-1:0] m_rb_addr = '0;
  logic          m_exp_fv = 1'b0;
  logic [IW-1:0] exp_q [$];

  int n_checks = 0;
  int n_pass   = 0;

  // Observed/expected values of the last step.
  logic          obs_fr, obs_lr, obs_wen;
  logic [AW-1:0] obs_addr;
  logic          exp_fg, exp_lg;
  logic [AW-1:0] exp_addr;

  // Scoreboard monitor: every cycle out of reset, fetch_v_o must match the model
  // and a valid word must equal the queued expectation.
  always @(negedge clk) begin
    logic [IW-1:0] want;
    if (reset_n === 1'b1) begin
      n_checks++;
      if (fetch_v_o !== m_exp_fv)
        $display("FAIL fetch_v_o: got %b expected %b at %0t", fetch_v_o, m_exp_fv, $time);
      else
        n_pass++;
      if (m_exp_fv && exp_q.size() > 0) begin
        want = exp_q.pop_front();
        n_checks++;
        if (fetch_instr_o !== want)
          $display("FAIL fetch_instr_o: got %h expected %h at %0t", fetch_instr_o, want, $time);
        else
          n_pass++;
      end
    end
  end

  // One clock of stimulus: drive at posedge+1, sample at posedge+4, advance model at the edge.
  task automatic step(input logic fv, input logic [AW-1:0] fa, input logic lv,
                      input logic [AW-1:0] la, input logic [IW-1:0] ld, input logic clr);
    fetch_v_i = fv; fetch_addr_i = fa;
    load_v_i = lv; load_addr_i = la; load_instr_i = ld; load_clear_i = clr;
    #3;
    exp_lg   = lv && (!fv || m_streak < LIM) && (m_st != 1);
    exp_fg   = fv && !exp_lg && (m_st != 1);
    exp_addr = exp_lg ? la : ((m_st == 1) ? m_rb_addr : fa);
    obs_fr = fetch_ready_o; obs_lr = load_ready_o; obs_wen = mem_wen_o; obs_addr = mem_addr_o;
    @(posedge clk);
    if (m_st != 1) begin
      if (!fv || exp_fg) m_streak = 0;
      else if (exp_lg && m_streak < LIM) m_streak++;
    end
    if (clr) m_count = 0;
    else if (exp_lg && m_count < DEPTH) m_count++;
    if (exp_fg) exp_q.push_back(m_mem[fa]);
    m_exp_fv = exp_fg;
    if (exp_lg) m_mem[la] = ld;
`ifdef IMEM_READBACK_EN
    if (m_st == 1) m_st = 2;
    else if (exp_lg) begin m_st = 1; m_rb_addr = la; end
    else m_st = 0;
`endif
    #1;
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic model_reset();
    m_streak = 0; m_count = 0; m_st = 0; m_exp_fv = 1'b0; exp_q.delete();
  endtask

  task automatic test_reset();
    n_checks++;
    if (fetch_v_o !== 1'b0) $display("FAIL reset_fetch_v: got %b expected 0", fetch_v_o); else n_pass++;
    n_checks++;
    if (load_count_o !== '0) $display("FAIL reset_count: got %0d expected 0", load_count_o); else n_pass++;
    n_checks++;
    if (err_o !== 1'b0) $display("FAIL reset_err: got %b expected 0", err_o); else n_pass++;
    n_checks++;
    if ({fetch_ready_o, load_ready_o, mem_wen_o} !== 3'b000)
      $display("FAIL reset_ready: got %b expected 000", {fetch_ready_o, load_ready_o, mem_wen_o});
    else n_pass++;
  endtask

  task automatic test_fetch();
    stub_mem[5] = 32'h0000_1234; m_mem[5] = 32'h0000_1234;
    idle();
    step(1'b1, 4'd5, 1'b0, '0, '0, 1'b0);
    n_checks++;
    if (obs_fr !== 1'b1 || obs_lr !== 1'b0 || obs_wen !== 1'b0)
      $display("FAIL fetch_grant: got fr=%b lr=%b wen=%b expected fr=1 lr=0 wen=0", obs_fr, obs_lr, obs_wen);
    else n_pass++;
    n_checks++;
    if (obs_addr !== 4'd5) $display("FAIL fetch_addr: got %0d expected 5", obs_addr); else n_pass++;
    idle();
  endtask

  task automatic test_load_count();
    for (int a = 0; a < 3; a++) begin
      for (int t = 0; t < 3; t++) begin
        step(1'b0, '0, 1'b1, 4'(a), 32'hC0DE_0000 + 32'(a), 1'b0);
        n_checks++;
        if (obs_lr !== exp_lg || obs_wen !== exp_lg || (exp_lg && obs_addr !== 4'(a)))
          $display("FAIL load_grant: got lr=%b wen=%b addr=%0d expected lr=%b addr=%0d", obs_lr, obs_wen, obs_addr, exp_lg, a);
        else n_pass++;
        if (exp_lg) break;
      end
    end
    n_checks++;
    if (load_count_o !== 5'd3) $display("FAIL load_count: got %0d expected 3", load_count_o); else n_pass++;
    idle();
    step(1'b0, '0, 1'b0, '0, '0, 1'b1);
    n_checks++;
    if (load_count_o !== '0) $display("FAIL load_clear: got %0d expected 0", load_count_o); else n_pass++;
    idle();
    step(1'b0, '0, 1'b1, 4'd9, 32'h9999, 1'b1);
    n_checks++;
    if (load_count_o !== '0) $display("FAIL clear_wins: got %0d expected 0", load_count_o); else n_pass++;
    idle(); idle();
  endtask

  task automatic test_starvation();
    idle(); idle();
    for (int i = 0; i < 15; i++) begin
      step(1'b1, 4'(i), 1'b1, 4'(i + 3), 32'h5A00_0000 + 32'(i), 1'b0);
      n_checks++;
      if (obs_fr !== exp_fg || obs_lr !== exp_lg)
        $display("FAIL starve_model[%0d]: got fr=%b lr=%b expected fr=%b lr=%b", i, obs_fr, obs_lr, exp_fg, exp_lg);
      else n_pass++;
`ifndef IMEM_READBACK_EN
      n_checks++;
      if (obs_fr !== (i % 5 == 4) || obs_lr !== (i % 5 != 4))
        $display("FAIL starve_pattern[%0d]: got fr=%b lr=%b expected fr=%b", i, obs_fr, obs_lr, (i % 5 == 4));
      else n_pass++;
`endif
    end
    idle(); idle();
  endtask

  task automatic test_load_then_fetch();
    step(1'b0, '0, 1'b1, 4'd7, 32'h0000_ABCD, 1'b0);
    for (int t = 0; t < 4; t++) begin
      step(1'b1, 4'd7, 1'b0, '0, '0, 1'b0);
      if (exp_fg) break;
    end
    n_checks++;
    if (obs_fr !== exp_fg || !exp_fg) $display("FAIL ltf_grant: got %b expected 1", obs_fr); else n_pass++;
    idle();
    n_checks++;
    if (m_mem[7] !== 32'h0000_ABCD) $display("FAIL ltf_model: got %h expected abcd", m_mem[7]); else n_pass++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 4'(15 - i), 1'b0, '0, '0, 1'b0);
      n_checks++;
      if (obs_fr !== 1'b1 || obs_addr !== 4'(15 - i))
        $display("FAIL b2b_fetch[%0d]: got fr=%b addr=%0d expected fr=1 addr=%0d", i, obs_fr, obs_addr, 15 - i);
      else n_pass++;
    end
    idle();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 2 * (DEPTH + 4); i++)
      step(1'b0, '0, 1'b1, 4'(i), 32'h1111_0000 + 32'(i), 1'b0);
    n_checks++;
    if (load_count_o !== 5'd16) $display("FAIL count_sat: got %0d expected 16", load_count_o); else n_pass++;
    idle(); idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 4'($urandom_range(0, DEPTH - 1)),
           1'($urandom_range(0, 2) != 0), 4'($urandom_range(0, DEPTH - 1)),
           $urandom, ($urandom_range(0, 15) == 0));
      n_checks++;
      if (obs_fr !== exp_fg || obs_lr !== exp_lg || obs_wen !== exp_lg || obs_addr !== exp_addr)
        $display("FAIL rand_grant[%0d]: got fr=%b lr=%b wen=%b addr=%0d expected fr=%b lr=%b addr=%0d",
                 i, obs_fr, obs_lr, obs_wen, obs_addr, exp_fg, exp_lg, exp_addr);
      else n_pass++;
      n_checks++;
      if (load_count_o !== 5'(m_count)) $display("FAIL rand_count[%0d]: got %0d expected %0d", i, load_count_o, m_count);
      else n_pass++;
    end
    idle(); idle();
    n_checks++;
    if (err_o !== 1'b0) $display("FAIL err_clean: got %b expected 0", err_o); else n_pass++;
  endtask

  task automatic test_reset_mid();
    step(1'b0, '0, 1'b1, 4'd2, 32'h2222, 1'b0);
    for (int t = 0; t < 4; t++) begin
      step(1'b1, 4'd2, 1'b0, '0, '0, 1'b0);
      if (exp_fg) break;
    end
    fetch_v_i = 1'b0;
    reset_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (fetch_v_o !== 1'b0) $display("FAIL rst_mid_fetch_v: got %b expected 0", fetch_v_o); else n_pass++;
    n_checks++;
    if (load_count_o !== '0) $display("FAIL rst_mid_count: got %0d expected 0", load_count_o); else n_pass++;
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle(); idle();
  endtask

`ifdef IMEM_READBACK_EN
  task automatic test_readback();
    step(1'b0, '0, 1'b1, 4'd3, 32'h0000_3333, 1'b0);
    corrupt = 1'b1;
    step(1'b1, 4'd8, 1'b1, 4'd4, 32'h4444, 1'b0);
    n_checks++;
    if (obs_fr !== 1'b0 || obs_lr !== 1'b0 || obs_wen !== 1'b0 || obs_addr !== 4'd3)
      $display("FAIL rb_rd: got fr=%b lr=%b wen=%b addr=%0d expected 0 0 0 3", obs_fr, obs_lr, obs_wen, obs_addr);
    else n_pass++;
    corrupt = 1'b0;
    idle();
    n_checks++;
    if (err_o !== 1'b1) $display("FAIL rb_err_set: got %b expected 1", err_o); else n_pass++;
    idle(); idle(); idle();
    n_checks++;
    if (err_o !== 1'b1) $display("FAIL rb_err_sticky: got %b expected 1", err_o); else n_pass++;
    reset_n = 1'b0; model_reset(); #1;
    n_checks++;
    if (err_o !== 1'b0) $display("FAIL rb_err_reset: got %b expected 0", err_o); else n_pass++;
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle();
  endtask
`endif

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      stub_mem[i] = 32'h0101_0101 * 32'(i + 1);
      m_mem[i]    = 32'h0101_0101 * 32'(i + 1);
    end
    reset_n = 1'b0;
    fetch_v_i = 1'b0; fetch_addr_i = '0;
    load_v_i = 1'b0; load_addr_i = '0; load_instr_i = '0; load_clear_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    reset_n = 1'b1;
    idle();
    test_fetch();
    test_load_count();
    test_starvation();
    test_load_then_fetch();
    test_back_to_back();
    test_saturation();
    test_random();
    test_reset_mid();
`ifdef IMEM_READBACK_EN
    test_readback();
`endif
    idle(); idle();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
